// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_pkg                                                        |
// | Purpose  : Shared state encodings and bus constants for the I2C target.  |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_RD_ACK   = 3'd6
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int          BITS_PER_BYTE = 8;
  localparam logic [3:0]  BIT_CNT_LAST  = 4'(BITS_PER_BYTE);

endpackage
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_sync_edge                                                  |
// | Purpose  : Multi-flop synchronizer (preset high) with rise/fall pulses.  |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_pin};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Preset to 1 so an idle (pulled-up) bus produces no edge out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign o_fall  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/i2c_target_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_target_receiver                                            |
// | Purpose  : I2C target: 7-bit address match, write-byte receive, ACK.     |
// |            Define I2C_TGT_READ_EN to add master-read support.            |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module i2c_target_receiver
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_scl,
  inout  wire        io_sda,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_busy,
  output logic       o_start_det,
`ifdef I2C_TGT_READ_EN
  input  logic [7:0] i_tx_data,
  output logic       o_tx_req,
`endif
  output logic       o_stop_det
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (i_scl),
    .o_level (scl_s),
    .o_rise  (scl_rise),
    .o_fall  (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (io_sda),
    .o_level (sda_s),
    .o_rise  (sda_rise),
    .o_fall  (sda_fall)
  );

  i2c_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       oe_q, oe_d;
`ifdef I2C_TGT_READ_EN
  logic       rw_q, rw_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_req_q, tx_req_d;
`endif

  logic start_cond, stop_cond, addr_hit;

  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;

  // General call (address 0) is never acknowledged.
`ifdef I2C_TGT_READ_EN
  assign addr_hit = (shift_q[7:1] == ADDRESS) && (ADDRESS != 7'd0);
`else
  assign addr_hit = (shift_q[7:1] == ADDRESS) && (ADDRESS != 7'd0) && (shift_q[0] == 1'b0);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    oe_d       = oe_q;
`ifdef I2C_TGT_READ_EN
    rw_d       = rw_q;
    tx_shift_d = tx_shift_q;
    tx_req_d   = 1'b0;
`endif
    if (start_cond) begin
      start_d = 1'b1;
      oe_d    = 1'b0;
      cnt_d   = 4'd0;
      busy_d  = 1'b0;
      state_d = ST_ADDR;
    end else if (stop_cond) begin
      stop_d  = 1'b1;
      oe_d    = 1'b0;
      cnt_d   = 4'd0;
      busy_d  = 1'b0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == BIT_CNT_LAST) begin
            cnt_d = 4'd0;
            if (addr_hit) begin
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              state_d = ST_ADDR_ACK;
`ifdef I2C_TGT_READ_EN
              rw_d    = shift_q[0];
`endif
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = ST_WR_DATA;
`ifdef I2C_TGT_READ_EN
            if (rw_q) begin
              // First read bit goes out on the same fall that ends the ACK.
              tx_shift_d = i_tx_data;
              tx_req_d   = 1'b1;
              oe_d       = ~i_tx_data[7];
              state_d    = ST_RD_DATA;
            end
`endif
          end
        end
        ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == BIT_CNT_LAST) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            oe_d       = 1'b1;
            state_d    = ST_WR_ACK;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = ST_WR_DATA;
          end
        end
`ifdef I2C_TGT_READ_EN
        ST_RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == BIT_CNT_LAST) begin
              oe_d    = 1'b0;
              state_d = ST_RD_ACK;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              oe_d       = ~tx_shift_q[6];
            end
          end
        end
        ST_RD_ACK: begin
          // cnt advances past the byte length to mark a received master ACK.
          if (scl_rise) begin
            if (sda_s == I2C_NACK) begin
              cnt_d   = 4'd0;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (scl_fall && cnt_q == BIT_CNT_LAST + 4'd1) begin
            tx_shift_d = i_tx_data;
            tx_req_d   = 1'b1;
            oe_d       = ~i_tx_data[7];
            cnt_d      = 4'd0;
            state_d    = ST_RD_DATA;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      oe_q       <= 1'b0;
`ifdef I2C_TGT_READ_EN
      rw_q       <= 1'b0;
      tx_shift_q <= 8'd0;
      tx_req_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      oe_q       <= oe_d;
`ifdef I2C_TGT_READ_EN
      rw_q       <= rw_d;
      tx_shift_q <= tx_shift_d;
      tx_req_q   <= tx_req_d;
`endif
    end
  end

  assign io_sda      = oe_q ? 1'b0 : 1'bz;
  assign o_rx_data   = rx_data_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_busy      = busy_q;
  assign o_start_det = start_q;
  assign o_stop_det  = stop_q;
`ifdef I2C_TGT_READ_EN
  assign o_tx_req    = tx_req_q;
`endif

endmodule
`default_nettype wire
